// File: rtl/alu_seq_unit.sv
// Sequential ALU: decodes aluop/funct into a 3-bit select and executes add/sub/or/nor in one
// cycle or sll/srl iteratively, SHIFT_STEP bits per cycle, behind valid/ready handshakes.
module alu_seq_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SHAMT_W    = $clog2(WIDTH) + 1,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [3:0]         funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2:0]         alu_sel,
  output logic               zero,
  output logic               ovf,
  output logic               err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] SEL_ILL = 3'b000;
  localparam logic [2:0] SEL_SLL = 3'b001;
  localparam logic [2:0] SEL_SRL = 3'b010;
  localparam logic [2:0] SEL_NOR = 3'b011;
  localparam logic [2:0] SEL_SUB = 3'b100;
  localparam logic [2:0] SEL_OR  = 3'b101;
  localparam logic [2:0] SEL_ADD = 3'b110;

  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(SHIFT_STEP);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         sel_q, sel_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               accept;
  logic [2:0]         dec_sel;
  logic [WIDTH-1:0]   sum, diff, shifted;
  logic               ovf_add, ovf_sub;
  logic [SHAMT_W-1:0] shamt_clip, step, cnt_rem;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign alu_sel   = sel_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  always_comb begin
    dec_sel = SEL_ILL;
    unique case (aluop)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      2'b10: begin
        case (funct)
          4'b0001: dec_sel = SEL_SLL;
          4'b0010: dec_sel = SEL_SRL;
          4'b0011: dec_sel = SEL_NOR;
          4'b0100: dec_sel = SEL_SUB;
          4'b0101: dec_sel = SEL_OR;
          4'b0110: dec_sel = SEL_ADD;
          default: dec_sel = SEL_ILL;
        endcase
      end
      default: dec_sel = SEL_ILL;
    endcase
  end

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
  assign ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (diff[WIDTH-1] != op_a[WIDTH-1]);

  // Clamping to WIDTH keeps the iteration count bounded; WIDTH shifted bits already give zero.
  assign shamt_clip = (shamt > WIDTH_C) ? WIDTH_C : shamt;
  assign step       = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  assign cnt_rem    = cnt_q - step;
  assign shifted    = (sel_q == SEL_SLL) ? (work_q << step) : (work_q >> step);

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sel_d    = sel_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_rem;
        if (cnt_rem == '0) begin
          state_d  = DONE;
          result_d = shifted;
          zero_d   = (shifted == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase

    // A new request overrides the DONE->IDLE drain when accepted in the same cycle.
    if (accept) begin
      state_d = DONE;
      sel_d   = dec_sel;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      case (dec_sel)
        SEL_ADD: begin
          result_d = sum;
          ovf_d    = ovf_add;
          zero_d   = (sum == '0);
        end
        SEL_SUB: begin
          result_d = diff;
          ovf_d    = ovf_sub;
          zero_d   = (diff == '0);
        end
        SEL_OR: begin
          result_d = op_a | op_b;
          zero_d   = ((op_a | op_b) == '0);
        end
        SEL_NOR: begin
          result_d = ~(op_a | op_b);
          zero_d   = (~(op_a | op_b) == '0);
        end
        SEL_SLL, SEL_SRL: begin
          if (shamt_clip == '0) begin
            result_d = op_a;
            zero_d   = (op_a == '0);
          end else begin
            state_d = SHIFT;
            work_d  = op_a;
            cnt_d   = shamt_clip;
            zero_d  = 1'b0;
          end
        end
        default: begin
          result_d = '0;
          err_d    = 1'b1;
          zero_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      sel_q    <= SEL_ILL;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

endmodule
